apb_master_interface: RTL and testbench
=======================================

Name: apb_master_interface

Overview:
APB-side initiator of the AHB-to-APB bridge. It takes decoded AHB transfers from the bridge's AHB slave front end (valid, address, write flag, one-hot peripheral select, write data) and runs APB setup/enable phases on up to three peripherals. It stalls the AHB master through hready_out until the APB access completes. It returns read data combinationally from the selected peripheral.

Parameters:
ADDR_W, 32, AHB/APB address width
DATA_W, 32, AHB/APB data width
NSEL, 3, number of APB peripheral selects (one-hot)

Ports:
hclk  in  1  bridge clock
hresetn  in  1  asynchronous active-low reset
valid  in  1  AHB address phase is an in-range NONSEQ/SEQ transfer with hready_in=1
hwrite  in  1  AHB write flag for the current address phase
haddr  in  ADDR_W  AHB address for the current address phase
hwdata  in  DATA_W  AHB write data, valid in the data phase
temp_sel  in  NSEL  one-hot peripheral select decoded from haddr
pready  in  1  APB peripheral ready; extends the enable phase
prdata  in  DATA_W  read data from the selected peripheral
pselx  out  NSEL  APB peripheral selects
penable  out  1  APB enable phase
pwrite  out  1  APB write flag
paddr  out  ADDR_W  APB address
pwdata  out  DATA_W  APB write data
hready_out  out  1  AHB ready back to the master
hrdata  out  DATA_W  AHB read data
hresp  out  2  AHB response, always OKAY (2'b00)

Behaviour:
- Accept condition: valid=1, temp_sel!=0, and the state is ST_IDLE, or the state is ST_RENABLE/ST_WENABLE with pready=1.
- On accept, register haddr→addr_q, temp_sel→sel_q, hwrite→write_q. Go to ST_READ if hwrite=0, else to ST_WWAIT.
- valid=1 with temp_sel=0 is ignored; the block stays in or returns to ST_IDLE.
- ST_IDLE: pselx=0, penable=0, hready_out=1.
- ST_READ (APB setup): pselx=sel_q, penable=0, pwrite=0, paddr=addr_q, hready_out=0. Always goes to ST_RENABLE next cycle.
- ST_RENABLE: pselx=sel_q, penable=1, hready_out=pready.
  - pready=0: stay in ST_RENABLE.
  - pready=1 with accept: go to ST_READ or ST_WWAIT per hwrite.
  - pready=1 without accept: go to ST_IDLE.
- ST_WWAIT: pselx=0, penable=0, hready_out=0. Capture hwdata→wdata_q at the end of the cycle. Always goes to ST_WRITE.
- ST_WRITE (APB setup): pselx=sel_q, penable=0, pwrite=1, paddr=addr_q, pwdata=wdata_q, hready_out=0. Always goes to ST_WENABLE.
- ST_WENABLE: same as ST_RENABLE except pwrite=1 and pwdata=wdata_q. Same pready and accept transitions.
- Latency, counted from the accept cycle as cycle 0:
  - Read: cycle 1 is setup, cycle 2 is enable, hready_out=1 and hrdata valid in cycle 2 when pready=1.
  - Write: cycle 1 is WWAIT, cycle 2 is setup, cycle 3 is enable.
  - Each pready=0 cycle adds one cycle.
- Back-to-back transfers: the completing enable cycle doubles as the next accept cycle. There is no idle gap between APB transfers.
- pselx, penable, pwrite, paddr and pwdata are registered, with no combinational path from the AHB inputs. paddr, pwrite and pwdata hold their last values in ST_IDLE and ST_WWAIT.
- hready_out is combinational from state and pready. hrdata = prdata combinationally. hresp is constant 2'b00.
- During setup (ST_READ, ST_WRITE), pready is ignored.
- Reset (asynchronous, including mid-transfer):
  - State goes to ST_IDLE immediately.
  - pselx=0, penable=0, pwrite=0, paddr=0, pwdata=0, addr_q=sel_q=wdata_q=0, write_q=0.
  - hready_out=1, hresp=00.
  - An aborted APB access is not resumed.

Decomposition:
- Shared package apb_bridge_pkg:
  - state enum ST_IDLE, ST_READ, ST_RENABLE, ST_WWAIT, ST_WRITE, ST_WENABLE
  - HRESP_OKAY=2'b00
  - select codes SEL_P0=3'b001, SEL_P1=3'b010, SEL_P2=3'b100
  - bridge address window constants
- Single module. No sub-module is natural: the block is one FSM plus capture registers.

Test Plan:
- Single read, haddr=0x8000_0010, temp_sel=001, pready=1, prdata=0xDEAD_BEEF → pselx=001 in cycles 1-2, penable=1 in cycle 2 only, paddr=0x8000_0010, hready_out 0→1 in cycle 2, hrdata=0xDEAD_BEEF.
- Single write, haddr=0x8400_0004, temp_sel=010, hwdata=0x1234_5678 in cycle 1 → pselx=010 with pwrite=1 in cycles 2-3, pwdata=0x1234_5678, penable=1 in cycle 3, hready_out=1 only in cycle 3.
- Write with pready held low 3 cycles in enable → state stays ST_WENABLE, all APB outputs stable, hready_out=0 for 3 cycles, then 1 for one cycle.
- Back-to-back read (0x8800_0000, temp_sel=100) then write (0x8000_0020) with valid held → write accepted in the read's completing enable cycle, pselx goes 100→000 (ST_WWAIT)→001, no ST_IDLE cycle.
- valid=1 with temp_sel=000 → pselx stays 0, hready_out stays 1, state stays ST_IDLE.
- hresetn asserted low in ST_WENABLE asynchronously (mid-cycle) → pselx, penable, paddr and pwdata go to 0 and hready_out goes to 1 before the next hclk edge; after release, a new read proceeds normally.

Source files
------------

// File: rtl/apb_bridge_pkg.sv
// Shared definitions for the AHB-to-APB bridge: FSM states, response codes,
// peripheral select codes and the bridge address window.
package apb_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_READ    = 3'd1,
    ST_RENABLE = 3'd2,
    ST_WWAIT   = 3'd3,
    ST_WRITE   = 3'd4,
    ST_WENABLE = 3'd5
  } apb_state_e;

  localparam logic [1:0] HRESP_OKAY = 2'b00;

  localparam logic [2:0] SEL_P0 = 3'b001;
  localparam logic [2:0] SEL_P1 = 3'b010;
  localparam logic [2:0] SEL_P2 = 3'b100;

  // Each peripheral owns a 64 MB slot starting at its base.
  localparam logic [31:0] P0_BASE    = 32'h8000_0000;
  localparam logic [31:0] P1_BASE    = 32'h8400_0000;
  localparam logic [31:0] P2_BASE    = 32'h8800_0000;
  localparam logic [31:0] BRIDGE_END = 32'h8BFF_FFFF;

  function automatic logic in_enable(input apb_state_e st);
    return (st == ST_RENABLE) || (st == ST_WENABLE);
  endfunction

endpackage

// File: rtl/apb_master_interface.sv
// APB initiator of the AHB-to-APB bridge: runs setup/enable phases for decoded
// AHB transfers and stalls the AHB master until the peripheral completes.
module apb_master_interface
  import apb_bridge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int NSEL   = 3
) (
  input  logic              hclk,
  input  logic              hresetn,
  input  logic              valid,
  input  logic              hwrite,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [DATA_W-1:0] hwdata,
  input  logic [NSEL-1:0]   temp_sel,
  input  logic              pready,
  input  logic [DATA_W-1:0] prdata,
  output logic [NSEL-1:0]   pselx,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  output logic              hready_out,
  output logic [DATA_W-1:0] hrdata,
  output logic [1:0]        hresp
);

  apb_state_e        state_r, state_s;
  logic              accept_s;
  logic [ADDR_W-1:0] addr_r, paddr_r, paddr_s;
  logic [NSEL-1:0]   sel_r, sel_s, pselx_r, pselx_s;
  logic              write_r, pwrite_r, pwrite_s, penable_r, penable_s;
  logic [DATA_W-1:0] wdata_r;
  logic              hready_s;

  // A new transfer is taken from idle or from an enable phase that is completing.
  always_comb begin
    accept_s = 1'b0;
    if (valid && (temp_sel != {NSEL{1'b0}})) begin
      if (state_r == ST_IDLE) begin
        accept_s = 1'b1;
      end else if (in_enable(state_r) && pready) begin
        accept_s = 1'b1;
      end else begin
        accept_s = 1'b0;
      end
    end else begin
      accept_s = 1'b0;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    if (accept_s) begin
      state_s = hwrite ? ST_WWAIT : ST_READ;
    end else begin
      case (state_r)
        ST_IDLE:    state_s = ST_IDLE;
        ST_READ:    state_s = ST_RENABLE;
        ST_RENABLE: state_s = pready ? ST_IDLE : ST_RENABLE;
        ST_WWAIT:   state_s = ST_WRITE;
        ST_WRITE:   state_s = ST_WENABLE;
        ST_WENABLE: state_s = pready ? ST_IDLE : ST_WENABLE;
        default:    state_s = ST_IDLE;
      endcase
    end
  end

  // APB outputs are computed for the next state so they can be registered;
  // paddr and pwrite only change on entry to a setup phase.
  always_comb begin
    sel_s     = accept_s ? temp_sel : sel_r;
    pselx_s   = {NSEL{1'b0}};
    penable_s = 1'b0;
    pwrite_s  = pwrite_r;
    paddr_s   = paddr_r;
    case (state_s)
      ST_READ: begin
        pselx_s  = sel_s;
        pwrite_s = 1'b0;
        paddr_s  = haddr;
      end
      ST_WRITE: begin
        pselx_s  = sel_s;
        pwrite_s = write_r;
        paddr_s  = addr_r;
      end
      ST_RENABLE, ST_WENABLE: begin
        pselx_s   = sel_s;
        penable_s = 1'b1;
      end
      ST_IDLE, ST_WWAIT: begin
        pselx_s   = {NSEL{1'b0}};
        penable_s = 1'b0;
      end
      default: begin
        pselx_s   = {NSEL{1'b0}};
        penable_s = 1'b0;
      end
    endcase
  end

  // State, transfer capture and registered APB outputs.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_r   <= ST_IDLE;
      addr_r    <= {ADDR_W{1'b0}};
      sel_r     <= {NSEL{1'b0}};
      write_r   <= 1'b0;
      wdata_r   <= {DATA_W{1'b0}};
      pselx_r   <= {NSEL{1'b0}};
      penable_r <= 1'b0;
      pwrite_r  <= 1'b0;
      paddr_r   <= {ADDR_W{1'b0}};
    end else begin
      state_r   <= state_s;
      pselx_r   <= pselx_s;
      penable_r <= penable_s;
      pwrite_r  <= pwrite_s;
      paddr_r   <= paddr_s;
      if (accept_s) begin
        addr_r  <= haddr;
        sel_r   <= temp_sel;
        write_r <= hwrite;
      end
      // Write data arrives in the AHB data phase, i.e. the wait cycle.
      if (state_r == ST_WWAIT) begin
        wdata_r <= hwdata;
      end
    end
  end

  // AHB ready: free in idle, follows pready in enable, stalled otherwise.
  always_comb begin
    hready_s = 1'b0;
    case (state_r)
      ST_IDLE:                hready_s = 1'b1;
      ST_RENABLE, ST_WENABLE: hready_s = pready;
      default:                hready_s = 1'b0;
    endcase
  end

  assign pselx      = pselx_r;
  assign penable    = penable_r;
  assign pwrite     = pwrite_r;
  assign paddr      = paddr_r;
  assign pwdata     = wdata_r;
  assign hready_out = hready_s;
  assign hrdata     = prdata;
  assign hresp      = HRESP_OKAY;

endmodule

// File: tb/tb_apb_master_interface.sv
// Bench for apb_master_interface: directed vector table, random traffic against
// a transfer-level reference model, and an asynchronous mid-transfer reset.
module tb_apb_master_interface;
  import apb_bridge_pkg::*;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic        valid, hwrite, pready;
  logic [31:0] haddr, hwdata, prdata;
  logic [2:0]  temp_sel;
  logic [2:0]  pselx;
  logic        penable, pwrite, hready_out;
  logic [31:0] paddr, pwdata, hrdata;
  logic [1:0]  hresp;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 hclk = ~hclk;

  apb_master_interface dut (
    .hclk(hclk), .hresetn(hresetn), .valid(valid), .hwrite(hwrite),
    .haddr(haddr), .hwdata(hwdata), .temp_sel(temp_sel), .pready(pready),
    .prdata(prdata), .pselx(pselx), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .hready_out(hready_out),
    .hrdata(hrdata), .hresp(hresp)
  );

  typedef struct {
    logic        v;
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [2:0]  s;
    logic        r;
    logic [31:0] rd;
    logic [2:0]  e_psel;
    logic        e_pen;
    logic        e_pwrite;
    logic [31:0] e_paddr;
    logic [31:0] e_pwdata;
    logic        e_hready;
  } vec_t;

  vec_t vec [23];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model: one outstanding transfer tracked by its age in cycles
  // since acceptance; setup falls at age 1 (read) or 2 (write).
  bit          m_busy, m_wr, m_pwrite;
  int          m_age;
  logic [31:0] m_addr, m_wdata, m_paddr, m_pwdata;
  logic [2:0]  m_sel;

  function automatic int setup_age();
    return m_wr ? 2 : 1;
  endfunction

  task automatic model_reset();
    m_busy = 1'b0; m_wr = 1'b0; m_pwrite = 1'b0; m_age = 0;
    m_addr = 32'h0; m_wdata = 32'h0; m_paddr = 32'h0; m_pwdata = 32'h0;
    m_sel = 3'b000;
  endtask

  task automatic model_check();
    logic [2:0] e_psel;
    logic       e_pen, e_rdy;
    if (!m_busy) begin
      e_psel = 3'b000; e_pen = 1'b0; e_rdy = 1'b1;
    end else if (m_age < setup_age()) begin
      e_psel = 3'b000; e_pen = 1'b0; e_rdy = 1'b0;
    end else if (m_age == setup_age()) begin
      e_psel = m_sel; e_pen = 1'b0; e_rdy = 1'b0;
    end else begin
      e_psel = m_sel; e_pen = 1'b1; e_rdy = pready;
    end
    chk("model_pselx", {29'h0, pselx}, {29'h0, e_psel});
    chk("model_penable", {31'h0, penable}, {31'h0, e_pen});
    chk("model_hready", {31'h0, hready_out}, {31'h0, e_rdy});
    chk("model_pwrite", {31'h0, pwrite}, {31'h0, m_pwrite});
    chk("model_paddr", paddr, m_paddr);
    chk("model_pwdata", pwdata, m_pwdata);
    chk("model_hrdata", hrdata, prdata);
    chk("model_hresp", {30'h0, hresp}, {30'h0, HRESP_OKAY});
  endtask

  task automatic model_step();
    bit done;
    if (!hresetn) begin
      model_reset();
      return;
    end
    done = !m_busy || ((m_age > setup_age()) && pready);
    if (m_busy && m_wr && (m_age == 1)) m_wdata = hwdata;
    if (done && valid && (temp_sel != 3'b000)) begin
      m_busy = 1'b1; m_wr = hwrite; m_addr = haddr; m_sel = temp_sel; m_age = 1;
    end else if (done) begin
      m_busy = 1'b0;
    end else begin
      m_age++;
    end
    if (m_busy && (m_age == setup_age())) begin
      m_paddr  = m_addr;
      m_pwrite = m_wr;
      if (m_wr) m_pwdata = m_wdata;
    end
  endtask

  task automatic cycle();
    @(negedge hclk);
    model_check();
    @(posedge hclk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    valid = 1'b0; hwrite = 1'b0; haddr = 32'h0; hwdata = 32'h0;
    temp_sel = 3'b000; pready = 1'b1; prdata = 32'h0;
  endtask

  function automatic vec_t mk(input logic v, input logic w, input logic [31:0] a,
                              input logic [31:0] d, input logic [2:0] s, input logic r,
                              input logic [31:0] rd, input logic [2:0] ep, input logic en,
                              input logic ew, input logic [31:0] ea, input logic [31:0] ed,
                              input logic eh);
    vec_t t;
    t.v = v; t.w = w; t.a = a; t.d = d; t.s = s; t.r = r; t.rd = rd;
    t.e_psel = ep; t.e_pen = en; t.e_pwrite = ew; t.e_paddr = ea; t.e_pwdata = ed;
    t.e_hready = eh;
    return t;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Single read, single write, write with wait states, back-to-back, bad select.
    vec[0]  = mk(1, 0, 32'h8000_0010, 32'h0, SEL_P0, 1, 32'h0, 3'b000, 0, 0, 32'h0, 32'h0, 1);
    vec[1]  = mk(0, 0, 32'h0, 32'h0, 3'b000, 0, 32'h0, SEL_P0, 0, 0, 32'h8000_0010, 32'h0, 0);
    vec[2]  = mk(0, 0, 32'h0, 32'h0, 3'b000, 1, 32'hDEAD_BEEF, SEL_P0, 1, 0, 32'h8000_0010, 32'h0, 1);
    vec[3]  = mk(1, 1, 32'h8400_0004, 32'h0, SEL_P1, 1, 32'h0, 3'b000, 0, 0, 32'h8000_0010, 32'h0, 1);
    vec[4]  = mk(0, 0, 32'h0, 32'h1234_5678, 3'b000, 1, 32'h0, 3'b000, 0, 0, 32'h8000_0010, 32'h0, 0);
    vec[5]  = mk(0, 0, 32'h0, 32'h0, 3'b000, 0, 32'h0, SEL_P1, 0, 1, 32'h8400_0004, 32'h1234_5678, 0);
    vec[6]  = mk(0, 0, 32'h0, 32'h0, 3'b000, 1, 32'h0, SEL_P1, 1, 1, 32'h8400_0004, 32'h1234_5678, 1);
    vec[7]  = mk(1, 1, 32'h8800_0008, 32'h0, SEL_P2, 1, 32'h0, 3'b000, 0, 1, 32'h8400_0004, 32'h1234_5678, 1);
    vec[8]  = mk(0, 0, 32'h0, 32'hA5A5_5A5A, 3'b000, 1, 32'h0, 3'b000, 0, 1, 32'h8400_0004, 32'h1234_5678, 0);
    vec[9]  = mk(0, 0, 32'h0, 32'h0, 3'b000, 1, 32'h0, SEL_P2, 0, 1, 32'h8800_0008, 32'hA5A5_5A5A, 0);
    vec[10] = mk(0, 0, 32'h0, 32'h0, 3'b000, 0, 32'h0, SEL_P2, 1, 1, 32'h8800_0008, 32'hA5A5_5A5A, 0);
    vec[11] = mk(1, 0, 32'h8000_0030, 32'h0, SEL_P0, 0, 32'h0, SEL_P2, 1, 1, 32'h8800_0008, 32'hA5A5_5A5A, 0);
    vec[12] = mk(0, 0, 32'h0, 32'h0, 3'b000, 0, 32'h0, SEL_P2, 1, 1, 32'h8800_0008, 32'hA5A5_5A5A, 0);
    vec[13] = mk(0, 0, 32'h0, 32'h0, 3'b000, 1, 32'h0, SEL_P2, 1, 1, 32'h8800_0008, 32'hA5A5_5A5A, 1);
    vec[14] = mk(1, 0, 32'h8800_0000, 32'h0, SEL_P2, 1, 32'h0, 3'b000, 0, 1, 32'h8800_0008, 32'hA5A5_5A5A, 1);
    vec[15] = mk(0, 0, 32'h0, 32'h0, 3'b000, 1, 32'h0, SEL_P2, 0, 0, 32'h8800_0000, 32'hA5A5_5A5A, 0);
    vec[16] = mk(1, 1, 32'h8000_0020, 32'h0, SEL_P0, 1, 32'h0BAD_F00D, SEL_P2, 1, 0, 32'h8800_0000, 32'hA5A5_5A5A, 1);
    vec[17] = mk(0, 0, 32'h0, 32'hCAFE_0001, 3'b000, 1, 32'h0, 3'b000, 0, 0, 32'h8800_0000, 32'hA5A5_5A5A, 0);
    vec[18] = mk(0, 0, 32'h0, 32'h0, 3'b000, 1, 32'h0, SEL_P0, 0, 1, 32'h8000_0020, 32'hCAFE_0001, 0);
    vec[19] = mk(0, 0, 32'h0, 32'h0, 3'b000, 1, 32'h0, SEL_P0, 1, 1, 32'h8000_0020, 32'hCAFE_0001, 1);
    vec[20] = mk(1, 0, 32'h8000_0000, 32'h0, 3'b000, 1, 32'h0, 3'b000, 0, 1, 32'h8000_0020, 32'hCAFE_0001, 1);
    vec[21] = mk(1, 1, 32'h8000_0000, 32'h0, 3'b000, 1, 32'h0, 3'b000, 0, 1, 32'h8000_0020, 32'hCAFE_0001, 1);
    vec[22] = mk(0, 0, 32'h0, 32'h0, 3'b000, 1, 32'h0, 3'b000, 0, 1, 32'h8000_0020, 32'hCAFE_0001, 1);

    idle_inputs();
    model_reset();
    hresetn = 1'b1;
    #1 hresetn = 1'b0;
    #2;
    chk("rst_pselx", {29'h0, pselx}, 32'h0);
    chk("rst_penable", {31'h0, penable}, 32'h0);
    chk("rst_pwrite", {31'h0, pwrite}, 32'h0);
    chk("rst_paddr", paddr, 32'h0);
    chk("rst_pwdata", pwdata, 32'h0);
    chk("rst_hready", {31'h0, hready_out}, 32'h1);
    chk("rst_hresp", {30'h0, hresp}, 32'h0);
    @(posedge hclk);
    @(posedge hclk);
    #1 hresetn = 1'b1;

    for (int i = 0; i < 23; i++) begin
      valid = vec[i].v; hwrite = vec[i].w; haddr = vec[i].a; hwdata = vec[i].d;
      temp_sel = vec[i].s; pready = vec[i].r; prdata = vec[i].rd;
      @(negedge hclk);
      chk($sformatf("row%0d_pselx", i), {29'h0, pselx}, {29'h0, vec[i].e_psel});
      chk($sformatf("row%0d_penable", i), {31'h0, penable}, {31'h0, vec[i].e_pen});
      chk($sformatf("row%0d_pwrite", i), {31'h0, pwrite}, {31'h0, vec[i].e_pwrite});
      chk($sformatf("row%0d_paddr", i), paddr, vec[i].e_paddr);
      chk($sformatf("row%0d_pwdata", i), pwdata, vec[i].e_pwdata);
      chk($sformatf("row%0d_hready", i), {31'h0, hready_out}, {31'h0, vec[i].e_hready});
      chk($sformatf("row%0d_hrdata", i), hrdata, vec[i].rd);
      model_check();
      @(posedge hclk);
      model_step();
      #1;
    end

    for (int i = 0; i < 400; i++) begin
      valid  = ($urandom_range(0, 3) != 0);
      hwrite = 1'($urandom_range(0, 1));
      haddr  = $urandom;
      hwdata = $urandom;
      prdata = $urandom;
      pready = ($urandom_range(0, 9) < 7);
      case ($urandom_range(0, 3))
        0:       temp_sel = 3'b000;
        1:       temp_sel = SEL_P0;
        2:       temp_sel = SEL_P1;
        default: temp_sel = SEL_P2;
      endcase
      cycle();
    end

    idle_inputs();
    for (int i = 0; i < 10; i++) cycle();

    // Write stalled in its enable phase, then reset asynchronously mid-cycle.
    valid = 1'b1; hwrite = 1'b1; haddr = 32'h8400_0040; temp_sel = SEL_P1;
    cycle();
    idle_inputs();
    hwdata = 32'h7777_8888;
    cycle();
    hwdata = 32'h0;
    cycle();
    pready = 1'b0;
    cycle();
    chk("stall_penable", {31'h0, penable}, 32'h1);
    #2 hresetn = 1'b0;
    #1;
    chk("arst_pselx", {29'h0, pselx}, 32'h0);
    chk("arst_penable", {31'h0, penable}, 32'h0);
    chk("arst_pwrite", {31'h0, pwrite}, 32'h0);
    chk("arst_paddr", paddr, 32'h0);
    chk("arst_pwdata", pwdata, 32'h0);
    chk("arst_hready", {31'h0, hready_out}, 32'h1);
    model_reset();
    pready = 1'b1;
    cycle();
    hresetn = 1'b1;
    cycle();

    // A fresh read after reset release proceeds normally.
    valid = 1'b1; hwrite = 1'b0; haddr = 32'h8000_0044; temp_sel = SEL_P0;
    cycle();
    idle_inputs();
    cycle();
    chk("post_rst_pselx", {29'h0, pselx}, {29'h0, SEL_P0});
    chk("post_rst_paddr", paddr, 32'h8000_0044);
    prdata = 32'h5A5A_1234;
    cycle();
    idle_inputs();
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
